fetch_stage_unit: RTL and testbench
===================================

# fetch_stage_unit

Instruction-fetch stage and IF/ID pipeline register of the five-stage MIPS core, directly upstream of the ID stage and its hazard detection unit. Owns the PC, issues requests on a ready-handshake instruction-memory port, and delivers {PC+4, instruction, valid} to ID. Freezes on the hazard unit's stall signal and redirects/flushes on a taken branch or jump resolved in EXE. Bubbles are inserted while memory is slow.

## Interface
- ADDR_W, 32, PC and memory address width
- INSTR_W, 32, instruction width
- RESET_PC, 32'h0000_0000, first fetch address after reset
---
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-low reset; sampled on rising edge of clk
- hazard_detected  input  1  freeze from hazard unit; hold PC and IF/ID
- branch_taken  input  1  redirect request from EXE; one-cycle pulse
- branch_addr  input  ADDR_W  redirect target, valid with branch_taken
- imem_req  output  1  memory request strobe
- imem_addr  output  ADDR_W  fetch address; stable while imem_req=1 and imem_ready=0
- imem_rdata  input  INSTR_W  instruction, valid when imem_ready=1
- imem_ready  input  1  response strobe; may be high in the same cycle as imem_req
- if_id_pc  output  ADDR_W  registered PC+4 of delivered instruction
- if_id_instr  output  INSTR_W  registered instruction
- if_id_valid  output  1  registered; 0 marks a bubble
- fetch_busy  output  1  1 while in S_REQ with imem_ready=0, or in S_DROP

## Operation
- States: S_REQ (request outstanding), S_HOLD (instruction captured in holding buffer, ID frozen), S_DROP (discarding a response orphaned by a redirect).
- imem_req = 1 in S_REQ and S_DROP; 0 in S_HOLD and while rst=0. imem_addr = pc in S_REQ, = the latched orphan address in S_DROP.
- S_REQ, imem_ready=1, no branch, no hazard: IF/ID <= {pc+4, imem_rdata, 1}; pc <= pc+4; stay in S_REQ.
- S_REQ, imem_ready=1, hazard, no branch: IF/ID held; buffer <= imem_rdata; go to S_HOLD; pc unchanged.
- S_REQ, imem_ready=0, no branch: IF/ID <= bubble {0,0,0} unless hazard (then held).
- S_HOLD, hazard=0: IF/ID <= {pc+4, buffer, 1}; pc <= pc+4; go to S_REQ. S_HOLD, hazard=1: hold everything.
- branch_taken (any state) has priority over hazard: IF/ID <= bubble; pc <= branch_addr.
  - From S_REQ with imem_ready=0: latch the old address, go to S_DROP.
  - Otherwise, including ready in the same cycle: response discarded; go to S_REQ.
- S_DROP: keep requesting the old address. On imem_ready, discard the data, go to S_REQ, and request pc next cycle. IF/ID is bubble unless hazard; a second branch_taken updates pc only.
- pc arithmetic is modulo 2^ADDR_W; 32'hFFFF_FFFC + 4 wraps to 0. No alignment check.

## Timing
- Reset (rst=0 at edge): pc=RESET_PC, state=S_REQ, if_id_pc=0, if_id_instr=0, if_id_valid=0, buffer=0. Outputs are valid the cycle after the edge. Reset mid-request abandons the transaction; the memory must tolerate a dropped request.
- Zero-wait memory: one instruction per cycle. Instruction requested in cycle N appears on the IF/ID outputs after edge N.
- N wait cycles: N bubbles, then the instruction.
- Redirect: the target is requested in the cycle after branch_taken, or in the cycle after the orphan response if in S_DROP. The first target instruction is on IF/ID two cycles after branch_taken with zero-wait memory.
- Hazard release from S_HOLD: the buffered instruction is on IF/ID at the first edge with hazard=0. The next request is issued in the following cycle.

## Test plan
- Reset then zero-wait memory returning addr-as-data: if_id_valid=0 after reset. Then if_id_pc=4,8,12 with if_id_instr=0,4,8 on consecutive cycles.
- Memory with 2 wait states: exactly two valid=0 cycles between instructions. imem_addr is stable during the waits. fetch_busy=1 during the waits.
- hazard_detected high for 3 cycles while ready=1 at pc=0x10: IF/ID holds its prior value for 3 cycles. Then if_id_pc=0x14, instr=mem[0x10]. No duplicate or skipped fetch.
- branch_taken to 0x100 during a wait at pc=0x20: enter S_DROP and complete 0x20 with data discarded. The next request is 0x100 and the first valid output is if_id_pc=0x104.
- branch_taken and hazard_detected in the same cycle: IF/ID becomes bubble and pc=branch_addr.
- rst low during an outstanding wait: all outputs reset and the next request is RESET_PC. Also check PC 0xFFFF_FFFC wraps to a request at 0.

Source files
------------

// File: rtl/fetch_stage_unit.sv
// Instruction-fetch stage with IF/ID pipeline register for the five-stage MIPS core.
// Owns the PC, drives a ready-handshake instruction port, and freezes/redirects on hazard and branch.
module fetch_stage_unit #(
   parameter int                ADDR_W   = 32,
   parameter int                INSTR_W  = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               hazard_detected,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  branch_addr,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               imem_ready,
   output logic [ADDR_W-1:0]  if_id_pc,
   output logic [INSTR_W-1:0] if_id_instr,
   output logic               if_id_valid,
   output logic               fetch_busy
);

   typedef enum logic [1:0] {S_REQ, S_HOLD, S_DROP} state_t;

   state_t               state, state_nxt;
   logic [ADDR_W-1:0]    pc, pc_nxt, pc_inc;
   logic [ADDR_W-1:0]    orphan, orphan_nxt;
   logic [INSTR_W-1:0]   buffer, buffer_nxt;
   logic [ADDR_W-1:0]    if_id_pc_nxt;
   logic [INSTR_W-1:0]   if_id_instr_nxt;
   logic                 if_id_valid_nxt;

   assign pc_inc     = pc + ADDR_W'(4);
   assign imem_req   = rst && (state != S_HOLD);
   assign imem_addr  = (state == S_DROP) ? orphan : pc;
   assign fetch_busy = (state == S_DROP) || ((state == S_REQ) && !imem_ready);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= S_REQ;
         pc          <= RESET_PC;
         buffer      <= '0;
         if_id_pc    <= '0;
         if_id_instr <= '0;
         if_id_valid <= 1'b0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         buffer      <= buffer_nxt;
         if_id_pc    <= if_id_pc_nxt;
         if_id_instr <= if_id_instr_nxt;
         if_id_valid <= if_id_valid_nxt;
      end
   end

   // Orphan address only matters once S_DROP is entered, which always loads it first.
   always_ff @(posedge clk) begin
      orphan <= orphan_nxt;
   end

   always_comb begin
      state_nxt       = state;
      pc_nxt          = pc;
      orphan_nxt      = orphan;
      buffer_nxt      = buffer;
      if_id_pc_nxt    = if_id_pc;
      if_id_instr_nxt = if_id_instr;
      if_id_valid_nxt = if_id_valid;

      if (branch_taken) begin
         // Redirect wins over a freeze: ID sees a bubble and fetch restarts at the target.
         if_id_pc_nxt    = '0;
         if_id_instr_nxt = '0;
         if_id_valid_nxt = 1'b0;
         pc_nxt          = branch_addr;
         case (state)
            S_REQ: begin
               if (!imem_ready) begin
                  orphan_nxt = pc;
                  state_nxt  = S_DROP;
               end else begin
                  state_nxt = S_REQ;
               end
            end
            S_DROP:  state_nxt = imem_ready ? S_REQ : S_DROP;
            default: state_nxt = S_REQ;
         endcase
      end else begin
         case (state)
            S_REQ: begin
               if (imem_ready) begin
                  if (hazard_detected) begin
                     buffer_nxt = imem_rdata;
                     state_nxt  = S_HOLD;
                  end else begin
                     if_id_pc_nxt    = pc_inc;
                     if_id_instr_nxt = imem_rdata;
                     if_id_valid_nxt = 1'b1;
                     pc_nxt          = pc_inc;
                  end
               end else if (!hazard_detected) begin
                  if_id_pc_nxt    = '0;
                  if_id_instr_nxt = '0;
                  if_id_valid_nxt = 1'b0;
               end
            end
            S_HOLD: begin
               if (!hazard_detected) begin
                  if_id_pc_nxt    = pc_inc;
                  if_id_instr_nxt = buffer;
                  if_id_valid_nxt = 1'b1;
                  pc_nxt          = pc_inc;
                  state_nxt       = S_REQ;
               end
            end
            S_DROP: begin
               if (imem_ready) begin
                  state_nxt = S_REQ;
               end
               if (!hazard_detected) begin
                  if_id_pc_nxt    = '0;
                  if_id_instr_nxt = '0;
                  if_id_valid_nxt = 1'b0;
               end
            end
            default: state_nxt = S_REQ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage_unit.sv
// Scoreboard bench for fetch_stage_unit: directed stimulus pushes expected IF/ID deliveries,
// a monitor pops and compares whenever IF/ID is written.
module tb_fetch_stage_unit;

   localparam logic [31:0] KEY = 32'h5A5A_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        hazard_detected;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instr;
   logic        if_id_valid;
   logic        fetch_busy;

   int   total = 0;
   int   bad   = 0;
   int   wait_n = 0;
   int   wcnt = 0;
   logic scramble = 1'b0;
   logic upd = 1'b0;
   exp_t sb[$];

   fetch_stage_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .hazard_detected(hazard_detected),
      .branch_taken(branch_taken), .branch_addr(branch_addr),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .imem_ready(imem_ready), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
      .if_id_valid(if_id_valid), .fetch_busy(fetch_busy)
   );

   always #5 clk = ~clk;

   // Instruction memory with a programmable number of wait states per request.
   assign imem_ready = rst && imem_req && (wcnt >= wait_n);
   assign imem_rdata = scramble ? (imem_addr ^ KEY) : imem_addr;

   always @(posedge clk) begin
      if (!rst || !imem_req || imem_ready) wcnt <= 0;
      else                                 wcnt <= wcnt + 1;
      upd <= !rst || !hazard_detected || branch_taken;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic expect_fetch(input logic [31:0] a);
      exp_t e;
      e.pc    = a + 32'd4;
      e.instr = scramble ? (a ^ KEY) : a;
      sb.push_back(e);
   endtask

   // Monitor: IF/ID was written at the last edge unless frozen by hazard without redirect.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (upd && if_id_valid) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_delivery: got pc %h instr %h expected none at %0t",
                        if_id_pc, if_id_instr, $time);
            end else begin
               e = sb.pop_front();
               chk("deliver_pc", if_id_pc, e.pc);
               chk("deliver_instr", if_id_instr, e.instr);
            end
         end else if (upd) begin
            chk("bubble_pc", if_id_pc, 32'h0);
            chk("bubble_instr", if_id_instr, 32'h0);
         end
      end
   end

   initial begin
      repeat (3000) @(posedge clk);
      $display("FAIL watchdog: got no finish expected finish within 3000 cycles");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0; hazard_detected = 1'b0; branch_taken = 1'b0; branch_addr = '0;
      repeat (2) @(negedge clk);
      // Reset state
      chk("rst_valid", 32'(if_id_valid), 32'h0);
      chk("rst_pc", if_id_pc, 32'h0);
      chk("rst_instr", if_id_instr, 32'h0);
      chk("rst_req", 32'(imem_req), 32'h0);

      // Zero-wait streaming, addr-as-data
      rst = 1'b1;
      expect_fetch(32'h0); expect_fetch(32'h4); expect_fetch(32'h8);
      repeat (3) @(negedge clk);

      // Two wait states on 0xC: two bubbles, stable address, busy
      wait_n = 2;
      expect_fetch(32'hC);
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("wait_busy", 32'(fetch_busy), 32'h1);
         chk("wait_addr", imem_addr, 32'hC);
         chk("wait_req", 32'(imem_req), 32'h1);
         @(negedge clk);
         chk("wait_bubble", 32'(if_id_valid), 32'h0);
      end
      #1 chk("wait_done_busy", 32'(fetch_busy), 32'h0);
      @(negedge clk);

      // Hazard for three cycles with ready=1 at pc=0x10
      wait_n = 0; scramble = 1'b1; hazard_detected = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("hold_valid", 32'(if_id_valid), 32'h1);
         chk("hold_pc", if_id_pc, 32'h10);
         chk("hold_instr", if_id_instr, 32'hC);
         #1 chk("hold_no_req", 32'(imem_req), 32'h0);
      end
      hazard_detected = 1'b0;
      expect_fetch(32'h10);
      @(negedge clk);
      expect_fetch(32'h14); expect_fetch(32'h18); expect_fetch(32'h1C);
      #1 chk("release_addr", imem_addr, 32'h14);
      repeat (3) @(negedge clk);

      // Branch to 0x100 during a wait at pc=0x20
      wait_n = 2; branch_taken = 1'b1; branch_addr = 32'h100;
      #1 chk("br_wait_busy", 32'(fetch_busy), 32'h1);
      chk("br_wait_addr", imem_addr, 32'h20);
      @(negedge clk);
      branch_taken = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("drop_addr", imem_addr, 32'h20);
         chk("drop_busy", 32'(fetch_busy), 32'h1);
         chk("drop_req", 32'(imem_req), 32'h1);
         @(negedge clk);
         chk("drop_bubble", 32'(if_id_valid), 32'h0);
      end
      expect_fetch(32'h100);
      #1 chk("redirect_addr", imem_addr, 32'h100);
      repeat (3) @(negedge clk);

      // Branch and hazard in the same cycle
      wait_n = 0; hazard_detected = 1'b1; branch_taken = 1'b1; branch_addr = 32'h200;
      @(negedge clk);
      chk("brhz_valid", 32'(if_id_valid), 32'h0);
      hazard_detected = 1'b0; branch_taken = 1'b0;
      expect_fetch(32'h200);
      #1 chk("brhz_addr", imem_addr, 32'h200);
      @(negedge clk);

      // Reset during an outstanding wait
      wait_n = 3;
      @(negedge clk);
      rst = 1'b0;
      #1 chk("rst_mid_req", 32'(imem_req), 32'h0);
      @(negedge clk);
      chk("rst_mid_valid", 32'(if_id_valid), 32'h0);
      chk("rst_mid_pc", if_id_pc, 32'h0);
      chk("rst_mid_instr", if_id_instr, 32'h0);
      rst = 1'b1; wait_n = 0;
      #1 chk("rst_restart_addr", imem_addr, 32'h0);
      chk("rst_restart_req", 32'(imem_req), 32'h1);
      expect_fetch(32'h0);
      @(negedge clk);

      // PC wrap from 0xFFFF_FFFC
      branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
      @(negedge clk);
      chk("wrap_br_valid", 32'(if_id_valid), 32'h0);
      branch_taken = 1'b0;
      expect_fetch(32'hFFFF_FFFC);
      #1 chk("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
      @(negedge clk);
      expect_fetch(32'h0);
      #1 chk("wrap_zero_addr", imem_addr, 32'h0);
      @(negedge clk);

      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("scoreboard_empty", 32'(sb.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
